// File: rtl/vc_pop_scheduler.sv
// Pop scheduler for the VC0/VC1 input FIFOs feeding the D0/D1 output mux.
// Strict VC0 priority with a VC1 starvation guard; stalls on downstream almost-full.
module vc_pop_scheduler #(
    parameter int unsigned BURST = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             VC0_empty,
    input  logic             VC0_almost_empty,
    input  logic             VC1_empty,
    input  logic             VC1_almost_empty,
    input  logic [5:0]       VC0_data,
    input  logic [5:0]       VC1_data,
    input  logic             D0_almost_full,
    input  logic             D1_almost_full,
    output logic             pop_VC0,
    output logic             pop_VC1,
    output logic             pop_delay_VC0,
    output logic             pop_delay_VC1,
    output logic             push_D0,
    output logic             push_D1,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] words_D0,
    output logic [CNT_W-1:0] words_D1
);

    localparam int unsigned BURST_W  = $clog2(BURST + 1);
    localparam int unsigned DEST_BIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               gnt0, gnt1;
    logic               elig0, elig1, stall;
    logic               dest0, dest1;
    logic               unused_data;

    // pop_delay doubles as the last-pop flag that guards a single-word FIFO
    assign elig0 = enable & ~VC0_empty & ~(VC0_almost_empty & pop_delay_VC0);
    assign elig1 = enable & ~VC1_empty & ~(VC1_almost_empty & pop_delay_VC1);
    assign stall = D0_almost_full | D1_almost_full;

    assign dest0 = VC0_data[DEST_BIT];
    assign dest1 = VC1_data[DEST_BIT];
    assign unused_data = ^{VC0_data[5], VC0_data[3:0], VC1_data[5], VC1_data[3:0]};

    // Grant arbitration, burst accounting and next state
    always_comb begin
        state_d = IDLE;
        burst_d = burst_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;

        if (!stall) begin
            if (elig0 && elig1 && (burst_q == BURST_W'(BURST))) begin
                gnt1 = 1'b1;
            end else if (elig0) begin
                gnt0 = 1'b1;
            end else if (elig1) begin
                gnt1 = 1'b1;
            end
        end

        if (gnt1 || VC1_empty) begin
            burst_d = '0;
        end else if (gnt0 && (burst_q != BURST_W'(BURST))) begin
            burst_d = burst_q + BURST_W'(1);
        end

        if (stall && (elig0 || elig1)) begin
            state_d = HOLD;
        end else if (gnt0) begin
            state_d = GNT0;
        end else if (gnt1) begin
            state_d = GNT1;
        end
    end

    assign pop_VC0 = gnt0 & ~reset;
    assign pop_VC1 = gnt1 & ~reset;
    assign state   = state_q;

    // State register and pop -> push pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            burst_q       <= '0;
            pop_delay_VC0 <= 1'b0;
            pop_delay_VC1 <= 1'b0;
            push_D0       <= 1'b0;
            push_D1       <= 1'b0;
            words_D0      <= '0;
            words_D1      <= '0;
        end else begin
            state_q       <= state_d;
            burst_q       <= burst_d;
            pop_delay_VC0 <= pop_VC0;
            pop_delay_VC1 <= pop_VC1;
            push_D0       <= (pop_delay_VC0 & ~dest0) | (pop_delay_VC1 & ~dest1);
            push_D1       <= (pop_delay_VC0 &  dest0) | (pop_delay_VC1 &  dest1);
            words_D0      <= words_D0 + CNT_W'(push_D0);
            words_D1      <= words_D1 + CNT_W'(push_D1);
        end
    end

endmodule

// File: tb/tb_vc_pop_scheduler.sv
// Bench for vc_pop_scheduler: queue-based FIFO models with late-updating flags,
// a cycle reference model of the grant rules, and directed plus random scenarios.
module tb_vc_pop_scheduler;

    localparam int unsigned BURST = 4;
    localparam int unsigned CNT_W = 8;
    localparam int          WRAP  = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             VC0_empty = 1'b1, VC0_almost_empty = 1'b0;
    logic             VC1_empty = 1'b1, VC1_almost_empty = 1'b0;
    logic [5:0]       VC0_data = '0, VC1_data = '0;
    logic             D0_almost_full = 1'b0, D1_almost_full = 1'b0;
    logic             pop_VC0, pop_VC1, pop_delay_VC0, pop_delay_VC1, push_D0, push_D1;
    logic [1:0]       state;
    logic [CNT_W-1:0] words_D0, words_D1;

    always #5 clk = ~clk;

    vc_pop_scheduler #(.BURST(BURST), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .VC0_empty(VC0_empty), .VC0_almost_empty(VC0_almost_empty),
        .VC1_empty(VC1_empty), .VC1_almost_empty(VC1_almost_empty),
        .VC0_data(VC0_data), .VC1_data(VC1_data),
        .D0_almost_full(D0_almost_full), .D1_almost_full(D1_almost_full),
        .pop_VC0(pop_VC0), .pop_VC1(pop_VC1),
        .pop_delay_VC0(pop_delay_VC0), .pop_delay_VC1(pop_delay_VC1),
        .push_D0(push_D0), .push_D1(push_D1), .state(state),
        .words_D0(words_D0), .words_D1(words_D1)
    );

    int tests = 0;
    int fails = 0;

    // FIFO contents; flags shown to the DUT lag the contents by one cycle
    logic [5:0] q0[$];
    logic [5:0] q1[$];
    int         f0 = 0, f1 = 0;
    logic [5:0] dat0 = '0, dat1 = '0;

    // Reference model state
    bit g0 = 0, g1 = 0;
    bit m_pd0 = 0, m_pd1 = 0, m_push0 = 0, m_push1 = 0;
    int m_state = 0, m_burst = 0, n_state = 0, n_burst = 0;
    int m_words0 = 0, m_words1 = 0;
    int pushes0_total = 0;
    int pops0_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply the effect of the rising edge that just passed
    task automatic advance();
        bit np0, np1;
        np0 = (m_pd0 && !dat0[4]) || (m_pd1 && !dat1[4]);
        np1 = (m_pd0 &&  dat0[4]) || (m_pd1 &&  dat1[4]);
        m_words0      = (m_words0 + int'(m_push0)) % WRAP;
        m_words1      = (m_words1 + int'(m_push1)) % WRAP;
        pushes0_total = pushes0_total + int'(m_push0);
        m_push0 = np0;
        m_push1 = np1;
        m_pd0   = g0;
        m_pd1   = g1;
        m_state = n_state;
        m_burst = n_burst;
        f0 = q0.size();
        f1 = q1.size();
        if (g0 && q0.size() > 0) dat0 = q0.pop_front();
        if (g1 && q1.size() > 0) dat1 = q1.pop_front();
    endtask

    task automatic drive_and_check(input bit en, input bit a0, input bit a1);
        bit e0, e1, st;
        enable           = en;
        D0_almost_full   = a0;
        D1_almost_full   = a1;
        VC0_empty        = (f0 == 0);
        VC0_almost_empty = (f0 == 1);
        VC1_empty        = (f1 == 0);
        VC1_almost_empty = (f1 == 1);
        VC0_data         = dat0;
        VC1_data         = dat1;
        #1;
        e0 = en && (f0 > 0) && !(f0 == 1 && m_pd0);
        e1 = en && (f1 > 0) && !(f1 == 1 && m_pd1);
        st = a0 || a1;
        g0 = 0;
        g1 = 0;
        if (!st) begin
            if (e0 && e1 && m_burst == BURST) g1 = 1;
            else if (e0) g0 = 1;
            else if (e1) g1 = 1;
        end
        if (g1 || f1 == 0) n_burst = 0;
        else if (g0 && m_burst < BURST) n_burst = m_burst + 1;
        else n_burst = m_burst;
        if (st && (e0 || e1)) n_state = 3;
        else if (g0) n_state = 1;
        else if (g1) n_state = 2;
        else n_state = 0;

        check("pop_VC0", 32'(pop_VC0), 32'(g0));
        check("pop_VC1", 32'(pop_VC1), 32'(g1));
        check("pop_delay_VC0", 32'(pop_delay_VC0), 32'(m_pd0));
        check("pop_delay_VC1", 32'(pop_delay_VC1), 32'(m_pd1));
        check("push_D0", 32'(push_D0), 32'(m_push0));
        check("push_D1", 32'(push_D1), 32'(m_push1));
        check("state", 32'(state), 32'(m_state));
        check("words_D0", 32'(words_D0), 32'(m_words0));
        check("words_D1", 32'(words_D1), 32'(m_words1));
        pops0_seen = pops0_seen + int'(pop_VC0);
    endtask

    task automatic cycle(input bit en, input bit a0, input bit a1);
        @(negedge clk);
        advance();
        drive_and_check(en, a0, a1);
    endtask

    task automatic do_reset(input bit clear_fifos);
        @(negedge clk);
        advance();
        reset = 1'b1;
        if (clear_fifos) begin
            q0.delete();
            q1.delete();
        end
        g0 = 0; g1 = 0; m_pd0 = 0; m_pd1 = 0; m_push0 = 0; m_push1 = 0;
        m_state = 0; m_burst = 0; n_state = 0; n_burst = 0;
        m_words0 = 0; m_words1 = 0;
        #1;
        check("rst_pop_VC0", 32'(pop_VC0), 32'd0);
        check("rst_pop_VC1", 32'(pop_VC1), 32'd0);
        check("rst_pop_delay", 32'({pop_delay_VC0, pop_delay_VC1}), 32'd0);
        check("rst_push", 32'({push_D0, push_D1}), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_words", 32'({words_D0, words_D1}), 32'd0);
        repeat (2) @(negedge clk);
        f0 = q0.size();
        f1 = q1.size();
        reset = 1'b0;
        drive_and_check(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [9:0] seq;
        int start, cyc, added;

        do_reset(1'b1);

        // Three VC0 words routed D0, D1, D0
        q0.push_back(6'h00);
        q0.push_back(6'h10);
        q0.push_back(6'h0A);
        pops0_seen = 0;
        repeat (8) cycle(1'b1, 1'b0, 1'b0);
        check("three_pops", 32'(pops0_seen), 32'd3);
        check("three_words_D0", 32'(words_D0), 32'd2);
        check("three_words_D1", 32'(words_D1), 32'd1);

        // Single word: one pop only despite the late empty flag
        q0.push_back(6'h15);
        pops0_seen = 0;
        repeat (5) cycle(1'b1, 1'b0, 1'b0);
        check("single_pop", 32'(pops0_seen), 32'd1);

        // Both VCs busy: VC0 x4 then VC1 x1
        for (int i = 0; i < 12; i++) begin
            q0.push_back(6'($urandom));
            q1.push_back(6'($urandom));
        end
        seq = '0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            seq = {seq[8:0], g1};
        end
        check("burst_pattern", 32'(seq), 32'(10'b0000100001));

        // Downstream almost-full holds off pops
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        check("hold_state", 32'(state), 32'd3);
        check("hold_no_pop", 32'({pop_VC0, pop_VC1}), 32'd0);
        cycle(1'b1, 1'b0, 1'b0);
        check("hold_resume", 32'(pop_VC0 | pop_VC1), 32'd1);

        // Disable mid-stream: pops stop, pipeline drains
        cycle(1'b0, 1'b0, 1'b0);
        check("disable_no_pop", 32'({pop_VC0, pop_VC1}), 32'd0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        check("disable_drained", 32'({push_D0, push_D1}), 32'd0);

        // Reset during a burst, then restart from VC0
        for (int i = 0; i < 6; i++) begin
            q0.push_back(6'($urandom));
            q1.push_back(6'($urandom));
        end
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        do_reset(1'b0);
        check("restart_vc0", 32'(pop_VC0), 32'd1);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0 && q0.size() < 16) q0.push_back(6'($urandom));
            if ($urandom_range(0, 2) == 0 && q1.size() < 16) q1.push_back(6'($urandom));
            cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0));
        end

        // 256 words to D0 wrap the counter
        do_reset(1'b1);
        start = pushes0_total;
        cyc   = 0;
        added = 0;
        while ((pushes0_total - start) < WRAP && cyc < 600) begin
            if (q0.size() < 4 && added < WRAP) begin
                q0.push_back(6'($urandom) & 6'h2F);
                added++;
            end
            cycle(1'b1, 1'b0, 1'b0);
            cyc++;
        end
        check("wrap_pushes", 32'(pushes0_total - start), 32'(WRAP));
        check("wrap_words_D0", 32'(words_D0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
